imem_access_ctrl: RTL and testbench

// - Owns the byte-wide instruction memory. Sequences boot-time program loading and shares the memory between
//   the loader (word writes) and the pipeline fetch stage (word reads).
// - Holds fetch stalled until loading is done. Each loader word is split into 4 little-endian byte writes.
// - Sits between the IF stage / PC register and the instruction memory array.

---
 rtl/imem_access_ctrl_if.sv | 38 +++
 rtl/imem_access_ctrl.sv | 128 ++++++++++++
 tb/tb_imem_access_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_access_ctrl_if.sv
// Loader, fetch and memory-port bundle shared by the instruction-memory access controller.
// Signal names carry the controller's direction (i_ into the controller, o_ out of it).
interface imem_access_ctrl_if #(
   parameter int CNT_W = 16
);
   logic              i_ld_valid;
   logic              o_ld_ready;
   logic [31:0]       i_ld_adr;
   logic [31:0]       i_ld_data;
   logic              i_ld_done;
   logic              o_ld_err;
   logic [CNT_W-1:0]  o_ld_count;

   logic [31:0]       i_fetch_adr;
   logic [31:0]       o_fetch_instr;
   logic              o_fetch_valid;
   logic              o_fetch_err;
   logic              o_stall;

   logic              o_mem_we;
   logic [31:0]       o_mem_wadr;
   logic [7:0]        o_mem_wbyte;
   logic [31:0]       o_mem_radr;
   logic [31:0]       i_mem_rdata;

   // Environment side: loader, IF stage and memory array
   modport master (
      output i_ld_valid, i_ld_adr, i_ld_data, i_ld_done, i_fetch_adr, i_mem_rdata,
      input  o_ld_ready, o_ld_err, o_ld_count, o_fetch_instr, o_fetch_valid,
             o_fetch_err, o_stall, o_mem_we, o_mem_wadr, o_mem_wbyte, o_mem_radr
   );

   modport slave (
      input  i_ld_valid, i_ld_adr, i_ld_data, i_ld_done, i_fetch_adr, i_mem_rdata,
      output o_ld_ready, o_ld_err, o_ld_count, o_fetch_instr, o_fetch_valid,
             o_fetch_err, o_stall, o_mem_we, o_mem_wadr, o_mem_wbyte, o_mem_radr
   );
endinterface

// File: rtl/imem_access_ctrl.sv
// Instruction-memory access controller: boot-time word loading as 4 little-endian byte writes,
// shared with combinational word fetch that is held stalled until loading is released.
//
// state   | meaning
// --------+---------------------------------------------------------------
// BOOT    | waiting for loader words, fetch stalled
// BOOT_WR | writing the 4 bytes of a boot word, fetch stalled
// RUN     | fetch live, loader words still accepted
// RUN_WR  | writing the 4 bytes of a late word, fetch stalled
module imem_access_ctrl #(
   parameter int MEM_BYTES = 129,
   parameter int CNT_W     = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   imem_access_ctrl_if.slave        bus
);

   localparam logic [1:0] S_BOOT    = 2'd0;
   localparam logic [1:0] S_BOOT_WR = 2'd1;
   localparam logic [1:0] S_RUN     = 2'd2;
   localparam logic [1:0] S_RUN_WR  = 2'd3;

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   logic [1:0]        r_state;
   logic [1:0]        r_byte_cnt;
   logic [31:0]       r_adr;
   logic [31:0]       r_data;
   logic              r_done_pend;
   logic              r_ld_err;
   logic [CNT_W-1:0]  r_ld_count;

   logic              w_idle;
   logic              w_wr;
   logic              w_accept;
   logic              w_ld_legal;
   logic              w_last_byte;
   logic [32:0]       w_ld_end;
   logic [32:0]       w_fetch_end;
   logic              w_run;
   logic              w_fetch_err;
   logic [CNT_W-1:0]  w_count_inc;

   assign w_idle      = (r_state == S_BOOT) || (r_state == S_RUN);
   assign w_wr        = (r_state == S_BOOT_WR) || (r_state == S_RUN_WR);
   assign w_accept    = bus.i_ld_valid && w_idle;
   // 33-bit sums so an address near 2^32 cannot wrap into range
   assign w_ld_end    = {1'b0, bus.i_ld_adr} + 33'd3;
   assign w_ld_legal  = (bus.i_ld_adr[1:0] == 2'b00) && (w_ld_end < MEM_LIMIT);
   assign w_last_byte = w_wr && (r_byte_cnt == 2'd3);
   assign w_count_inc = (r_ld_count == {CNT_W{1'b1}}) ? r_ld_count : r_ld_count + 1'b1;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= S_BOOT;
         r_byte_cnt  <= 2'd0;
         r_adr       <= 32'd0;
         r_data      <= 32'd0;
         r_done_pend <= 1'b0;
         r_ld_err    <= 1'b0;
         r_ld_count  <= '0;
      end else begin
         r_ld_err <= w_accept && !w_ld_legal;
         case (r_state)
            S_BOOT: begin
               if (w_accept && w_ld_legal) begin
                  r_state     <= S_BOOT_WR;
                  r_adr       <= bus.i_ld_adr;
                  r_data      <= bus.i_ld_data;
                  r_byte_cnt  <= 2'd0;
                  r_done_pend <= bus.i_ld_done;
               end else if (bus.i_ld_done) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_accept && w_ld_legal) begin
                  r_state    <= S_RUN_WR;
                  r_adr      <= bus.i_ld_adr;
                  r_data     <= bus.i_ld_data;
                  r_byte_cnt <= 2'd0;
               end
            end
            S_BOOT_WR: begin
               if (w_last_byte) begin
                  r_state     <= (r_done_pend || bus.i_ld_done) ? S_RUN : S_BOOT;
                  r_done_pend <= 1'b0;
                  r_ld_count  <= w_count_inc;
               end else begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (bus.i_ld_done) begin
                     r_done_pend <= 1'b1;
                  end
               end
            end
            default: begin
               if (w_last_byte) begin
                  r_state    <= S_RUN;
                  r_ld_count <= w_count_inc;
               end else begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
               end
            end
         endcase
      end
   end

   // byte_cnt parks at 3 after a word, so address/data outputs hold the last byte written
   assign bus.o_mem_we    = w_wr;
   assign bus.o_mem_wadr  = r_adr + {30'd0, r_byte_cnt};
   assign bus.o_mem_wbyte = r_data[{r_byte_cnt, 3'b000} +: 8];

   assign bus.o_ld_ready  = w_idle;
   assign bus.o_ld_err    = r_ld_err;
   assign bus.o_ld_count  = r_ld_count;

   assign w_run           = (r_state == S_RUN);
   assign w_fetch_end     = {1'b0, bus.i_fetch_adr} + 33'd3;
   assign w_fetch_err     = w_run && ((bus.i_fetch_adr[1:0] != 2'b00) || (w_fetch_end >= MEM_LIMIT));

   assign bus.o_mem_radr    = bus.i_fetch_adr;
   assign bus.o_fetch_err   = w_fetch_err;
   assign bus.o_fetch_valid = w_run && !w_fetch_err;
   assign bus.o_fetch_instr = (w_run && !w_fetch_err) ? bus.i_mem_rdata : 32'h0000_0013;
   assign bus.o_stall       = !w_run;

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl: stimulus queues expected byte writes, error pulses and
// fetch responses; a negedge monitor pops and compares them as the controller presents them.
module tb_imem_access_ctrl;

   localparam int CNT_W = 16;

   typedef struct packed {
      logic [31:0] adr;
      logic [7:0]  wbyte;
   } wr_t;

   typedef struct packed {
      logic [31:0] instr;
      logic        valid;
      logic        err;
   } fe_t;

   logic i_clk;
   logic i_rst;

   imem_access_ctrl_if #(.CNT_W(CNT_W)) bus ();

   imem_access_ctrl #(.MEM_BYTES(129), .CNT_W(CNT_W)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   wr_t         wq[$];
   int          eq[$];
   fe_t         fq[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          exp_count = 0;
   logic        fetch_strobe = 1'b0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] adr, input logic [31:0] data, input int nbytes);
      wr_t e;
      for (int i = 0; i < nbytes; i++) begin
         e.adr   = adr + 32'(i);
         e.wbyte = data[8*i +: 8];
         wq.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] adr, input logic [31:0] data, input bit legal);
      int n;
      if (legal) push_word(adr, data, 4);
      else eq.push_back(exp_count);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_adr   = adr;
      bus.i_ld_data  = data;
      n = 0;
      while (!bus.o_ld_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         n_checks++;
         n_errors++;
         $display("FAIL ld_ready_timeout: got ready=0 expected ready=1 within 50 cycles");
      end
      step();
      bus.i_ld_valid = 1'b0;
      if (legal) begin
         exp_count++;
         repeat (4) step();
      end else begin
         step();
      end
   endtask

   task automatic fetch_chk(input logic [31:0] adr, input logic [31:0] rdata,
                            input logic [31:0] exp_instr, input logic exp_valid, input logic exp_err);
      fe_t e;
      e.instr = exp_instr;
      e.valid = exp_valid;
      e.err   = exp_err;
      fq.push_back(e);
      bus.i_fetch_adr = adr;
      bus.i_mem_rdata = rdata;
      fetch_strobe    = 1'b1;
      step();
      fetch_strobe    = 1'b0;
   endtask

   // Monitor
   always @(negedge i_clk) begin
      wr_t w;
      fe_t f;
      int  c;
      if (bus.o_mem_we) begin
         if (wq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write: got adr 0x%0h byte 0x%0h expected no write",
                     bus.o_mem_wadr, bus.o_mem_wbyte);
         end else begin
            w = wq.pop_front();
            chk("wr_adr", bus.o_mem_wadr, w.adr);
            chk("wr_byte", {24'd0, bus.o_mem_wbyte}, {24'd0, w.wbyte});
         end
      end
      if (bus.o_ld_err) begin
         if (eq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_ld_err: got pulse expected none");
         end else begin
            c = eq.pop_front();
            chk("err_count_unchanged", {16'd0, bus.o_ld_count}, 32'(c));
         end
      end
      if (fetch_strobe && fq.size() != 0) begin
         f = fq.pop_front();
         chk("fetch_instr", bus.o_fetch_instr, f.instr);
         chk("fetch_valid", {31'd0, bus.o_fetch_valid}, {31'd0, f.valid});
         chk("fetch_err", {31'd0, bus.o_fetch_err}, {31'd0, f.err});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lows;
      int stalls;
      i_rst           = 1'b1;
      bus.i_ld_valid  = 1'b0;
      bus.i_ld_adr    = 32'd0;
      bus.i_ld_data   = 32'd0;
      bus.i_ld_done   = 1'b0;
      bus.i_fetch_adr = 32'h1C;
      bus.i_mem_rdata = 32'h0262_8863;
      repeat (3) step();

      // reset state
      chk("rst_ready", {31'd0, bus.o_ld_ready}, 32'd1);
      chk("rst_stall", {31'd0, bus.o_stall}, 32'd1);
      chk("rst_count", {16'd0, bus.o_ld_count}, 32'd0);
      chk("rst_we", {31'd0, bus.o_mem_we}, 32'd0);
      chk("rst_fetch_valid", {31'd0, bus.o_fetch_valid}, 32'd0);
      chk("rst_fetch_instr_nop", bus.o_fetch_instr, 32'h0000_0013);
      i_rst = 1'b0;
      step();

      // first boot word
      send_word(32'h0, 32'h0040_0293, 1'b1);
      chk("w0_count", {16'd0, bus.o_ld_count}, 32'd1);
      chk("w0_stall", {31'd0, bus.o_stall}, 32'd1);
      chk("w0_hold_wadr", bus.o_mem_wadr, 32'h3);
      chk("w0_hold_wbyte", {24'd0, bus.o_mem_wbyte}, 32'h00);

      // back-to-back words with valid held
      push_word(32'h4, 32'h1122_3344, 4);
      push_word(32'h8, 32'hAABB_CCDD, 4);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_adr   = 32'h4;
      bus.i_ld_data  = 32'h1122_3344;
      step();
      bus.i_ld_adr   = 32'h8;
      bus.i_ld_data  = 32'hAABB_CCDD;
      lows = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge i_clk);
         if (!bus.o_ld_ready) lows++;
      end
      @(negedge i_clk);
      bus.i_ld_valid = 1'b0;
      chk("b2b_ready_low_cycles", 32'(lows), 32'd8);
      chk("b2b_ready_back", {31'd0, bus.o_ld_ready}, 32'd1);
      exp_count = 3;
      step();
      chk("b2b_count", {16'd0, bus.o_ld_count}, 32'd3);

      // illegal words, then the highest legal word
      send_word(32'h2, 32'h5555_5555, 1'b0);
      send_word(32'h80, 32'h6666_6666, 1'b0);
      chk("illegal_count", {16'd0, bus.o_ld_count}, 32'd3);
      send_word(32'h7C, 32'hDEAD_BEEF, 1'b1);
      chk("top_word_count", {16'd0, bus.o_ld_count}, 32'd4);

      // load release during the second byte
      push_word(32'h10, 32'h0102_0304, 4);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_adr   = 32'h10;
      bus.i_ld_data  = 32'h0102_0304;
      step();
      bus.i_ld_valid = 1'b0;
      step();
      bus.i_ld_done = 1'b1;
      step();
      bus.i_ld_done = 1'b0;
      step();
      chk("done_byte3_stall", {31'd0, bus.o_stall}, 32'd1);
      step();
      chk("done_run_stall", {31'd0, bus.o_stall}, 32'd0);
      chk("done_count", {16'd0, bus.o_ld_count}, 32'd5);
      exp_count = 5;

      // fetch path in RUN
      fetch_chk(32'h1C, 32'h0262_8863, 32'h0262_8863, 1'b1, 1'b0);
      fetch_chk(32'h1E, 32'h0262_8863, 32'h0000_0013, 1'b0, 1'b1);
      fetch_chk(32'h80, 32'h1234_5678, 32'h0000_0013, 1'b0, 1'b1);
      fetch_chk(32'h7C, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0);

      // late load while fetching
      bus.i_fetch_adr = 32'h1C;
      push_word(32'h60, 32'hCAFE_F00D, 4);
      bus.i_ld_valid = 1'b1;
      bus.i_ld_adr   = 32'h60;
      bus.i_ld_data  = 32'hCAFE_F00D;
      step();
      bus.i_ld_valid = 1'b0;
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge i_clk);
         if (bus.o_stall) stalls++;
      end
      chk("run_wr_stall_cycles", 32'(stalls), 32'd4);
      chk("run_wr_count", {16'd0, bus.o_ld_count}, 32'd6);

      // reset during byte 2 of a late word
      push_word(32'h64, 32'h0123_4567, 2);
      step();
      bus.i_ld_valid = 1'b1;
      bus.i_ld_adr   = 32'h64;
      bus.i_ld_data  = 32'h0123_4567;
      step();
      bus.i_ld_valid = 1'b0;
      step();
      step();
      i_rst = 1'b1;
      @(negedge i_clk);
      chk("abort_stall", {31'd0, bus.o_stall}, 32'd1);
      chk("abort_ready", {31'd0, bus.o_ld_ready}, 32'd1);
      chk("abort_count", {16'd0, bus.o_ld_count}, 32'd0);
      chk("abort_we", {31'd0, bus.o_mem_we}, 32'd0);
      step();
      i_rst = 1'b0;
      step();
      chk("post_rst_fetch_valid", {31'd0, bus.o_fetch_valid}, 32'd0);

      repeat (2) step();
      chk("wq_drained", 32'(wq.size()), 32'd0);
      chk("eq_drained", 32'(eq.size()), 32'd0);
      chk("fq_drained", 32'(fq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
